// File: rtl/multicycle_cu.sv
// Multi-cycle control sequencer for the CPU datapath.
// Steps each instruction through FETCH, DECODE, EXEC, MEM and WB. The datapath
// strobes are decoded from the state register, the opcode latched in DECODE,
// and, where needed, the live zero and mem_ready inputs.
// Memory accesses wait on mem_ready, bounded by MEM_TIMEOUT cycles. Running out
// of time enters a sticky FAULT state that only rst_n leaves.
//
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   run               permit a new fetch (sampled at instruction boundaries)
//   opcode            00 R-type, 01 LW, 10 SW, 11 BEQ
//   zero              ALU zero flag
//   mem_ready         memory completes the current access this cycle
//   pc_write..alu_op  datapath strobes
//   state             current state code
//   fault             sticky memory-timeout indicator
//   instr_count       retired-instruction counter, wraps modulo 2^CNT_W
module multicycle_cu #(
    parameter int unsigned MEM_TIMEOUT = 8,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [1:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_src,
    output logic             ir_write,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [2:0]       state,
    output logic             fault,
    output logic [CNT_W-1:0] instr_count
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT);

    localparam logic [1:0] OP_R   = 2'b00;
    localparam logic [1:0] OP_LW  = 2'b01;
    localparam logic [1:0] OP_SW  = 2'b10;
    localparam logic [1:0] OP_BEQ = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_FAULT  = 3'd6
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                retire;
    logic                wait_last;

    // State and datapath-context registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_R;
            wait_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
        end
    end

    // Last permitted wait cycle of a memory access
    assign wait_last = (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

    // Next-state and strobe decode. The wait counter defaults to zero, so it
    // is cleared on every entry into FETCH or MEM.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        wait_d     = '0;
        cnt_d      = cnt_q;
        retire     = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready)      state_d = S_DECODE;
                else if (wait_last) state_d = S_FAULT;
                else                wait_d  = wait_q + WAIT_W'(1);
            end
            S_DECODE: begin
                op_d      = opcode;
                alu_src_b = 2'b11;
                state_d   = S_EXEC;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                case (op_q)
                    OP_R: begin
                        alu_op  = 2'b10;
                        state_d = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_src_b = 2'b10;
                        state_d   = S_MEM;
                    end
                    default: begin
                        alu_op   = 2'b01;
                        pc_src   = 1'b1;
                        pc_write = zero;
                        retire   = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                i_or_d    = 1'b1;
                mem_read  = (op_q == OP_LW);
                mem_write = (op_q == OP_SW);
                if (mem_ready) begin
                    if (op_q == OP_LW) state_d = S_WB;
                    else               retire  = 1'b1;
                end else if (wait_last) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (op_q == OP_R);
                mem_to_reg = (op_q == OP_LW);
                retire     = 1'b1;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Instruction boundary: count it and decide whether to keep fetching
        if (retire) begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = run ? S_FETCH : S_IDLE;
        end
    end

    assign state       = state_q;
    assign fault       = (state_q == S_FAULT);
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_cu.sv
// Directed self-checking bench for multicycle_cu. A second instance with a
// 4-bit counter exercises the instr_count wrap in a short run.
module tb_multicycle_cu;

    logic        clk = 1'b0;
    logic        rst_n, run, zero, mem_ready;
    logic [1:0]  opcode;
    logic        pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write;
    logic        reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, alu_op;
    logic [2:0]  state;
    logic        fault;
    logic [15:0] instr_count;

    logic        w_rst_n;
    logic        w_pc_write, w_pc_src, w_ir_write, w_i_or_d, w_mem_read, w_mem_write;
    logic        w_reg_dst, w_mem_to_reg, w_reg_write, w_alu_src_a;
    logic [1:0]  w_alu_src_b, w_alu_op;
    logic [2:0]  w_state;
    logic        w_fault;
    logic [3:0]  w_instr_count;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    // {pc_write,pc_src,ir_write,i_or_d,mem_read,mem_write,reg_dst,mem_to_reg,reg_write,alu_src_a,alu_src_b,alu_op}
    logic [13:0] sb;
    assign sb = {pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write,
                 reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op};

    localparam logic [13:0] SB_ZERO      = 14'b0_0_0_0_0_0_0_0_0_0_00_00;
    localparam logic [13:0] SB_FETCH_RDY = 14'b1_0_1_0_1_0_0_0_0_0_01_00;
    localparam logic [13:0] SB_FETCH_WT  = 14'b0_0_0_0_1_0_0_0_0_0_01_00;
    localparam logic [13:0] SB_DECODE    = 14'b0_0_0_0_0_0_0_0_0_0_11_00;
    localparam logic [13:0] SB_EXEC_R    = 14'b0_0_0_0_0_0_0_0_0_1_00_10;
    localparam logic [13:0] SB_EXEC_MEM  = 14'b0_0_0_0_0_0_0_0_0_1_10_00;
    localparam logic [13:0] SB_EXEC_BZ1  = 14'b1_1_0_0_0_0_0_0_0_1_00_01;
    localparam logic [13:0] SB_EXEC_BZ0  = 14'b0_1_0_0_0_0_0_0_0_1_00_01;
    localparam logic [13:0] SB_MEM_LW    = 14'b0_0_0_1_1_0_0_0_0_0_00_00;
    localparam logic [13:0] SB_MEM_SW    = 14'b0_0_0_1_0_1_0_0_0_0_00_00;
    localparam logic [13:0] SB_WB_R      = 14'b0_0_0_0_0_0_1_0_1_0_00_00;
    localparam logic [13:0] SB_WB_LW     = 14'b0_0_0_0_0_0_0_1_1_0_00_00;

    multicycle_cu #(.MEM_TIMEOUT(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src),
        .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .state(state), .fault(fault), .instr_count(instr_count)
    );

    multicycle_cu #(.MEM_TIMEOUT(8), .CNT_W(4)) u_wrap (
        .clk(clk), .rst_n(w_rst_n), .run(1'b1), .opcode(2'b11), .zero(1'b0),
        .mem_ready(1'b1), .pc_write(w_pc_write), .pc_src(w_pc_src),
        .ir_write(w_ir_write), .i_or_d(w_i_or_d), .mem_read(w_mem_read),
        .mem_write(w_mem_write), .reg_dst(w_reg_dst), .mem_to_reg(w_mem_to_reg),
        .reg_write(w_reg_write), .alu_src_a(w_alu_src_a), .alu_src_b(w_alu_src_b),
        .alu_op(w_alu_op), .state(w_state), .fault(w_fault), .instr_count(w_instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cs(input string tag, input logic [2:0] st, input logic [13:0] s);
        chk({tag, " state"}, 32'(state), 32'(st));
        chk({tag, " strobes"}, 32'(sb), 32'(s));
    endtask

    // Advance one clock, drive this cycle's inputs, then let decode settle
    task automatic cyc(input logic r, input logic [1:0] op, input logic z, input logic mr);
        @(posedge clk);
        #1;
        run = r; opcode = op; zero = z; mem_ready = mr;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; w_rst_n = 1'b0;
        run = 1'b0; opcode = 2'b00; zero = 1'b0; mem_ready = 1'b0;

        // Reset state
        #12;
        cs("reset", 3'd0, SB_ZERO);
        chk("reset fault", 32'(fault), 32'd0);
        chk("reset count", 32'(instr_count), 32'd0);
        rst_n = 1'b1; run = 1'b1; mem_ready = 1'b1;

        // R-type, zero-wait memory: 1,2,3,5
        cyc(1'b1, 2'b00, 1'b0, 1'b1); cs("R fetch", 3'd1, SB_FETCH_RDY);
        cyc(1'b1, 2'b00, 1'b0, 1'b1); cs("R decode", 3'd2, SB_DECODE);
        cyc(1'b1, 2'b01, 1'b0, 1'b1); cs("R exec", 3'd3, SB_EXEC_R);
        cyc(1'b1, 2'b01, 1'b0, 1'b1); cs("R wb", 3'd5, SB_WB_R);
        chk("R count before retire", 32'(instr_count), 32'd0);

        // LW with three wait cycles in MEM; opcode disturbed after DECODE
        cyc(1'b1, 2'b01, 1'b0, 1'b1); cs("LW fetch", 3'd1, SB_FETCH_RDY);
        chk("R retired count", 32'(instr_count), 32'd1);
        cyc(1'b1, 2'b01, 1'b0, 1'b1); cs("LW decode", 3'd2, SB_DECODE);
        cyc(1'b1, 2'b11, 1'b0, 1'b1); cs("LW exec", 3'd3, SB_EXEC_MEM);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 2'b11, 1'b0, 1'b0); cs("LW mem wait", 3'd4, SB_MEM_LW);
        end
        cyc(1'b1, 2'b11, 1'b0, 1'b1); cs("LW mem done", 3'd4, SB_MEM_LW);
        cyc(1'b1, 2'b11, 1'b0, 1'b1); cs("LW wb", 3'd5, SB_WB_LW);

        // BEQ taken then not taken
        cyc(1'b1, 2'b11, 1'b0, 1'b1); cs("BEQ1 fetch", 3'd1, SB_FETCH_RDY);
        chk("LW retired count", 32'(instr_count), 32'd2);
        cyc(1'b1, 2'b11, 1'b0, 1'b1); cs("BEQ1 decode", 3'd2, SB_DECODE);
        cyc(1'b1, 2'b11, 1'b1, 1'b1); cs("BEQ1 exec z1", 3'd3, SB_EXEC_BZ1);
        cyc(1'b1, 2'b11, 1'b1, 1'b1); cs("BEQ2 fetch", 3'd1, SB_FETCH_RDY);
        chk("BEQ1 retired count", 32'(instr_count), 32'd3);
        cyc(1'b1, 2'b11, 1'b1, 1'b1); cs("BEQ2 decode", 3'd2, SB_DECODE);
        cyc(1'b1, 2'b11, 1'b0, 1'b1); cs("BEQ2 exec z0", 3'd3, SB_EXEC_BZ0);

        // SW with run dropped in EXEC: retires to IDLE, no further fetch
        cyc(1'b1, 2'b10, 1'b0, 1'b1); cs("SW fetch", 3'd1, SB_FETCH_RDY);
        chk("BEQ2 retired count", 32'(instr_count), 32'd4);
        cyc(1'b1, 2'b10, 1'b0, 1'b1); cs("SW decode", 3'd2, SB_DECODE);
        cyc(1'b0, 2'b10, 1'b0, 1'b1); cs("SW exec", 3'd3, SB_EXEC_MEM);
        cyc(1'b0, 2'b10, 1'b0, 1'b1); cs("SW mem", 3'd4, SB_MEM_SW);
        cyc(1'b0, 2'b10, 1'b0, 1'b1); cs("SW idle", 3'd0, SB_ZERO);
        chk("SW retired count", 32'(instr_count), 32'd5);
        cyc(1'b1, 2'b00, 1'b0, 1'b0); cs("idle holds", 3'd0, SB_ZERO);

        // FETCH timeout: eight wait cycles then sticky FAULT
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 2'b00, 1'b0, 1'b0); cs("timeout fetch", 3'd1, SB_FETCH_WT);
        end
        cyc(1'b1, 2'b00, 1'b0, 1'b1); cs("fault entered", 3'd6, SB_ZERO);
        chk("fault flag", 32'(fault), 32'd1);
        cyc(1'b1, 2'b00, 1'b0, 1'b1); cs("fault sticky", 3'd6, SB_ZERO);
        chk("fault count kept", 32'(instr_count), 32'd5);
        rst_n = 1'b0;
        #1;
        cs("fault reset", 3'd0, SB_ZERO);
        chk("fault reset flag", 32'(fault), 32'd0);
        chk("fault reset count", 32'(instr_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // mem_ready on the last allowed wait cycle completes without fault
        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, 2'b00, 1'b0, 1'b0); cs("late fetch wait", 3'd1, SB_FETCH_WT);
        end
        cyc(1'b1, 2'b00, 1'b0, 1'b1); cs("late fetch done", 3'd1, SB_FETCH_RDY);
        cyc(1'b1, 2'b00, 1'b0, 1'b1); cs("late decode", 3'd2, SB_DECODE);
        cyc(1'b1, 2'b00, 1'b0, 1'b1); cs("late exec", 3'd3, SB_EXEC_R);
        cyc(1'b1, 2'b00, 1'b0, 1'b1); cs("late wb", 3'd5, SB_WB_R);

        // Reset in WB aborts without retiring; strobes drop at once
        rst_n = 1'b0;
        #1;
        cs("abort reset", 3'd0, SB_ZERO);
        chk("abort count", 32'(instr_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Counter wrap on the 4-bit instance: back-to-back BEQs, 3 cycles each
        @(negedge clk);
        w_rst_n = 1'b1;
        repeat (1 + 3 * 15) @(posedge clk);
        #2;
        chk("wrap count 15", 32'(w_instr_count), 32'd15);
        chk("wrap state fetch", 32'(w_state), 32'd1);
        repeat (3) @(posedge clk);
        #2;
        chk("wrap count 0", 32'(w_instr_count), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
